// File: rtl/log_pkg.sv
// Shared definitions for the log arbiter: entry layout, field offsets and FSM states.
package log_pkg;

  localparam int unsigned NDT_FIXED_W = 32;

  // Flag bits + host data + ndt, where ndt is the tag plus a fixed 32-bit descriptor.
  function automatic int unsigned log_entry_width(input int unsigned data_w,
                                                  input int unsigned tag_w);
    return 4 + data_w + tag_w + NDT_FIXED_W;
  endfunction

  localparam int unsigned LOG_ENTRY_W = log_entry_width(32, 8);

  localparam int unsigned PARITY_BIT     = 75;
  localparam int unsigned HOST_READY_BIT = 74;
  localparam int unsigned NET_READY_BIT  = 73;
  localparam int unsigned NET_ACK_BIT    = 72;
  localparam int unsigned HOST_DATA_HI   = 71;
  localparam int unsigned HOST_DATA_LO   = 40;
  localparam int unsigned NDT_HI         = 39;
  localparam int unsigned NDT_LO         = 0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/log_fifo.sv
// Circular-buffer FIFO with a registered head entry, occupancy count and synchronous clear.
module log_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 76
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_entry,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_head_valid;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;
  logic             w_bypass;
  logic [WIDTH-1:0] w_head_next;

  assign o_full       = (r_count == CW'(DEPTH));
  assign w_push       = i_push && !i_clear && !o_full;
  assign w_pop        = i_pop && r_head_valid && !i_clear;
  assign w_rd_next    = r_rd_ptr + AW'(w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // When the FIFO drains to empty in this cycle, the entry being written becomes the head.
  assign w_bypass    = w_push && (r_count == CW'(w_pop));
  assign w_head_next = w_bypass ? i_din : r_mem[w_rd_next];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr     <= w_rd_next;
      r_count      <= w_count_next;
      r_head_valid <= (w_count_next != '0);
      if ((w_pop || !r_head_valid) && (w_count_next != '0)) begin
        r_head <= w_head_next;
      end
    end
  end

  assign o_valid = r_head_valid;
  assign o_entry = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/log_arbiter.sv
// Two-port round-robin log arbiter feeding a FIFO, with flush and acceptance counter.
module log_arbiter
  import log_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned TAG_SIZE  = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [1:0]                                        req_valid,
  input  logic [2*log_entry_width(DATA_SIZE, TAG_SIZE)-1:0] req_entry,
  output logic [1:0]                                        req_ready,
  input  logic                                              flush,
  output logic                                              out_valid,
  output logic [log_entry_width(DATA_SIZE, TAG_SIZE)-1:0]   out_entry,
  input  logic                                              out_ready,
  output logic [$clog2(DEPTH):0]                            count,
  output logic [15:0]                                       accepted
);

  localparam int unsigned EW = log_entry_width(DATA_SIZE, TAG_SIZE);

  state_t        r_state;
  logic          r_last_grant;
  logic [15:0]   r_accepted;

  logic          w_full;
  logic          w_flush_now;
  logic [1:0]    w_grant;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_din;

  assign w_flush_now = (r_state == RUN) && flush;

  // Grant depends only on request, history, fullness and state; never on out_ready.
  always_comb begin
    w_grant = 2'b00;
    if (!reset && (r_state == RUN) && !flush && !w_full) begin
      unique case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign w_push    = |w_grant;
  assign w_din     = w_grant[1] ? req_entry[2*EW-1:EW] : req_entry[EW-1:0];
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_last_grant <= 1'b1;
      r_accepted   <= '0;
    end else begin
      unique case (r_state)
        RUN:     r_state <= flush ? FLUSH : RUN;
        FLUSH:   r_state <= RUN;
        default: r_state <= RUN;
      endcase
      if (w_push) begin
        r_last_grant <= w_grant[1];
        if (r_accepted != '1) begin
          r_accepted <= r_accepted + 16'd1;
        end
      end
    end
  end

  assign accepted = r_accepted;

  log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_flush_now),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_entry (out_entry),
    .o_count (count),
    .o_full  (w_full)
  );

endmodule
